axi_sram_slave: RTL and testbench

//  AXI responder that gives the CPU's SRAM-like-to-AXI bridge (an AXI initiator) a memory to talk to.

---
 rtl/axi_sram_slave_if.sv | 65 ++++++
 rtl/axi_sram_slave.sv | 161 ++++++++++++++++
 tb/tb_axi_sram_slave.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI4 read/write channel bundle between an initiator and the
// SRAM-backed responder. The initiator uses the master modport, the responder uses slave.
interface axi_sram_slave_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 responder serving one FIXED/INCR burst at a time against a
// single-port synchronous SRAM with one cycle of read latency.
module axi_sram_slave #(
    parameter int ADDR_W = 14,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    axi_sram_slave_if.slave   axi,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [2:0]      size_q, size_d;
    logic [1:0]      burst_q, burst_d;
    logic [7:0]      beatCnt_q, beatCnt_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            lastWasWrite_q, lastWasWrite_d;

    logic            lastBeat;
    logic            grantRd;
    logic            grantWr;
    logic [31:0]     nextAddr;

    assign lastBeat = (beatCnt_q == len_q);
    assign nextAddr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);

    // On contention the channel that was not served most recently wins
    assign grantRd = (state_q == IDLE) && axi.arvalid && (!axi.awvalid || lastWasWrite_q);
    assign grantWr = (state_q == IDLE) && axi.awvalid && !grantRd;

    assign axi.arready = grantRd;
    assign axi.awready = grantWr;
    assign axi.wready  = (state_q == WR_DATA);
    assign axi.rvalid  = (state_q == RD_RESP);
    assign axi.rid     = id_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = 2'b00;
    assign axi.rlast   = (state_q == RD_RESP) && lastBeat;
    assign axi.bvalid  = (state_q == WR_RESP);
    assign axi.bid     = id_q;
    assign axi.bresp   = ((state_q == WR_RESP) && err_q) ? 2'b10 : 2'b00;
    assign ram_addr    = addr_q[ADDR_W+1:2];
    assign ram_wdata   = axi.wdata;

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        addr_d         = addr_q;
        len_d          = len_q;
        size_d         = size_q;
        burst_d        = burst_q;
        beatCnt_d      = beatCnt_q;
        err_d          = err_q;
        rdata_d        = rdata_q;
        lastWasWrite_d = lastWasWrite_q;
        ram_en         = 1'b0;
        ram_we         = 4'b0000;

        case (state_q)
            IDLE: begin
                if (grantRd) begin
                    id_d           = axi.arid;
                    addr_d         = axi.araddr;
                    len_d          = axi.arlen;
                    size_d         = axi.arsize;
                    burst_d        = axi.arburst;
                    beatCnt_d      = 8'd0;
                    lastWasWrite_d = 1'b0;
                    state_d        = RD_REQ;
                end else if (grantWr) begin
                    id_d           = axi.awid;
                    addr_d         = axi.awaddr;
                    len_d          = axi.awlen;
                    size_d         = axi.awsize;
                    burst_d        = axi.awburst;
                    beatCnt_d      = 8'd0;
                    err_d          = 1'b0;
                    lastWasWrite_d = 1'b1;
                    state_d        = WR_DATA;
                end
            end
            RD_REQ: begin
                ram_en  = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_d = ram_rdata;
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (axi.rready) begin
                    if (lastBeat) begin
                        state_d = IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q + 8'd1;
                        addr_d    = nextAddr;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                if (axi.wvalid) begin
                    ram_en = 1'b1;
                    ram_we = axi.wstrb;
                    // A misplaced wlast is reported in bresp but the burst still runs to len
                    if (axi.wlast != lastBeat) begin
                        err_d = 1'b1;
                    end
                    if (lastBeat) begin
                        state_d = WR_RESP;
                    end else begin
                        beatCnt_d = beatCnt_q + 8'd1;
                        addr_d    = nextAddr;
                    end
                end
            end
            WR_RESP: begin
                if (axi.bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            id_q           <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            beatCnt_q      <= '0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
            lastWasWrite_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            size_q         <= size_d;
            burst_q        <= burst_d;
            beatCnt_q      <= beatCnt_d;
            err_q          <= err_d;
            rdata_q        <= rdata_d;
            lastWasWrite_q <= lastWasWrite_d;
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: drives randomized AXI read/write bursts into axi_sram_slave and
// compares every response against a word-array memory model updated from the AXI rules.
module tb_axi_sram_slave;
    localparam int ADDR_W    = 14;
    localparam int ID_W      = 4;
    localparam int MEM_WORDS = 1 << ADDR_W;
    localparam int MAX_CYC   = 4000;

    logic              clk = 1'b0;
    logic              resetn;
    logic              ramEn;
    logic [3:0]        ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [31:0]       ramWdata;
    logic [31:0]       ramRdata;
    logic              loadEn;

    logic [31:0] sramMem [MEM_WORDS];
    logic [31:0] refMem  [MEM_WORDS];

    int checks = 0;
    int errors = 0;
    logic refLastWrite;
    logic [31:0] lastRdata;

    logic            rdEn;
    logic [ID_W-1:0] rdId;
    logic [31:0]     rdAddr;
    logic [7:0]      rdLen;
    logic [1:0]      rdBurst;
    logic [2:0]      rdSize;
    int              rdMode;

    logic            wrEn;
    logic [ID_W-1:0] wrId;
    logic [31:0]     wrAddr;
    logic [7:0]      wrLen;
    logic [1:0]      wrBurst;
    logic [2:0]      wrSize;
    int              wrLastIdx;
    int              bMode;
    logic [31:0]     wrData [256];
    logic [3:0]      wrStrb [256];

    axi_sram_slave_if #(.ID_W(ID_W)) axiIf();

    axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .axi       (axiIf),
        .ram_en    (ramEn),
        .ram_we    (ramWe),
        .ram_addr  (ramAddr),
        .ram_wdata (ramWdata),
        .ram_rdata (ramRdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM with byte enables and one cycle of read latency
    always @(posedge clk) begin
        if (loadEn) begin
            for (int i = 0; i < MEM_WORDS; i++) sramMem[i] <= refMem[i];
        end else if (ramEn) begin
            for (int b = 0; b < 4; b++) begin
                if (ramWe[b]) sramMem[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
            end
            ramRdata <= sramMem[ramAddr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] beatWord(input logic [31:0] base, input int k,
                                                   input logic [1:0] burst, input logic [2:0] size);
        logic [31:0] a;
        a = (burst == 2'b00) ? base : base + (32'(k) << size);
        return a[ADDR_W+1:2];
    endfunction

    task automatic setRead(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int mode);
        rdEn = 1'b1; rdId = id; rdAddr = addr; rdLen = len;
        rdBurst = burst; rdSize = size; rdMode = mode;
    endtask

    task automatic setWrite(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit earlyLast);
        wrEn = 1'b1; wrId = id; wrAddr = addr; wrLen = len;
        wrBurst = burst; wrSize = size;
        wrLastIdx = (earlyLast && len != 8'd0) ? int'(len) - 1 : int'(len);
        bMode = $urandom_range(0, 1);
        for (int i = 0; i < 256; i++) begin
            wrData[i] = $urandom;
            wrStrb[i] = 4'($urandom);
        end
    endtask

    // Runs the pending read and/or write to completion, servicing all five channels each cycle
    task automatic applyStimulus();
        int cyc = 0;
        int rBeat = 0;
        int wBeat = 0;
        int arCyc = -1;
        int firstCh = -1;
        int lastCh = -1;
        int expFirst;
        bit rDone, bDone, hsAr, hsAw, hsR, hsW, hsB;
        bit bothReady = 0;
        bit heldValid = 0;
        bit rvalidSeen = 0;
        logic [31:0] heldData;
        logic heldLast;
        logic rTog = 1'b1;
        logic [ADDR_W-1:0] w;

        expFirst = refLastWrite ? 0 : 1;
        rDone = !rdEn;
        bDone = !wrEn;
        @(negedge clk);
        axiIf.arvalid = rdEn; axiIf.arid = rdId; axiIf.araddr = rdAddr;
        axiIf.arlen = rdLen; axiIf.arsize = rdSize; axiIf.arburst = rdBurst;
        axiIf.awvalid = wrEn; axiIf.awid = wrId; axiIf.awaddr = wrAddr;
        axiIf.awlen = wrLen; axiIf.awsize = wrSize; axiIf.awburst = wrBurst;
        axiIf.wvalid = wrEn; axiIf.wdata = wrData[0]; axiIf.wstrb = wrStrb[0];
        axiIf.wlast = (wrLastIdx == 0);
        axiIf.rready = (rdMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        axiIf.bready = (bMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));

        while (!(rDone && bDone) && cyc < MAX_CYC) begin
            #1;
            hsAr = axiIf.arvalid && axiIf.arready;
            hsAw = axiIf.awvalid && axiIf.awready;
            hsR  = axiIf.rvalid && axiIf.rready;
            hsW  = axiIf.wvalid && axiIf.wready;
            hsB  = axiIf.bvalid && axiIf.bready;
            if (axiIf.arready && axiIf.awready) bothReady = 1;

            if (axiIf.rvalid && !rvalidSeen) begin
                rvalidSeen = 1;
                checkOutput("rd_latency", 32'(cyc - arCyc), 32'd3);
            end
            if (heldValid && axiIf.rvalid) begin
                checkOutput("rd_stable_data", axiIf.rdata, heldData);
                checkOutput("rd_stable_last", 32'(axiIf.rlast), 32'(heldLast));
            end
            heldValid = axiIf.rvalid && !axiIf.rready;
            heldData  = axiIf.rdata;
            heldLast  = axiIf.rlast;

            if (hsR) begin
                w = beatWord(rdAddr, rBeat, rdBurst, rdSize);
                checkOutput("rd_data", axiIf.rdata, refMem[w]);
                checkOutput("rd_id", 32'(axiIf.rid), 32'(rdId));
                checkOutput("rd_last", 32'(axiIf.rlast), 32'(rBeat == int'(rdLen)));
                checkOutput("rd_resp", 32'(axiIf.rresp), 32'd0);
                lastRdata = axiIf.rdata;
                rBeat++;
                if (rBeat > int'(rdLen)) rDone = 1;
            end
            if (hsW) begin
                w = beatWord(wrAddr, wBeat, wrBurst, wrSize);
                for (int b = 0; b < 4; b++) begin
                    if (axiIf.wstrb[b]) refMem[w][8*b +: 8] = axiIf.wdata[8*b +: 8];
                end
            end
            if (hsB) begin
                checkOutput("wr_bid", 32'(axiIf.bid), 32'(wrId));
                checkOutput("wr_bresp", 32'(axiIf.bresp),
                            (wrLastIdx == int'(wrLen)) ? 32'd0 : 32'd2);
                bDone = 1;
            end
            if (hsAr) begin
                arCyc = cyc;
                if (firstCh < 0) firstCh = 0;
                lastCh = 0;
            end
            if (hsAw) begin
                if (firstCh < 0) firstCh = 1;
                lastCh = 1;
            end

            @(posedge clk);
            @(negedge clk);
            if (hsAr) axiIf.arvalid = 1'b0;
            if (hsAw) axiIf.awvalid = 1'b0;
            if (hsW) begin
                wBeat++;
                if (wBeat > int'(wrLen)) begin
                    axiIf.wvalid = 1'b0;
                end else begin
                    axiIf.wdata = wrData[wBeat];
                    axiIf.wstrb = wrStrb[wBeat];
                    axiIf.wlast = (wBeat == wrLastIdx);
                end
            end
            if (rdMode == 1) begin
                rTog = ~rTog;
                axiIf.rready = rTog;
            end else if (rdMode == 2) begin
                axiIf.rready = 1'($urandom_range(0, 1));
            end
            if (bMode != 0) axiIf.bready = 1'($urandom_range(0, 1));
            cyc++;
        end

        if (cyc >= MAX_CYC) checkOutput("timeout", 32'd1, 32'd0);
        checkOutput("ready_excl", 32'(bothReady), 32'd0);
        if (rdEn && wrEn) checkOutput("grant_order", 32'(firstCh), 32'(expFirst));
        if (lastCh >= 0) refLastWrite = (lastCh == 1);
        axiIf.arvalid = 1'b0; axiIf.awvalid = 1'b0; axiIf.wvalid = 1'b0;
        axiIf.rready = 1'b0; axiIf.bready = 1'b0;
        rdEn = 1'b0; wrEn = 1'b0;
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        loadEn = 1'b0;
        rdEn = 1'b0; wrEn = 1'b0; rdMode = 0; bMode = 0; wrLastIdx = 0;
        axiIf.arvalid = 1'b0; axiIf.awvalid = 1'b0; axiIf.wvalid = 1'b0;
        axiIf.rready = 1'b0; axiIf.bready = 1'b0;
        axiIf.arid = '0; axiIf.araddr = '0; axiIf.arlen = '0; axiIf.arsize = '0; axiIf.arburst = '0;
        axiIf.awid = '0; axiIf.awaddr = '0; axiIf.awlen = '0; axiIf.awsize = '0; axiIf.awburst = '0;
        axiIf.wdata = '0; axiIf.wstrb = '0; axiIf.wlast = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = $urandom;
        refMem[14'h100] = 32'hDEADBEEF;
        refLastWrite = 1'b1;

        @(negedge clk); loadEn = 1'b1;
        @(negedge clk); loadEn = 1'b0;
        #1;
        checkOutput("rst_arready", 32'(axiIf.arready), 32'd0);
        checkOutput("rst_awready", 32'(axiIf.awready), 32'd0);
        checkOutput("rst_wready", 32'(axiIf.wready), 32'd0);
        checkOutput("rst_rvalid", 32'(axiIf.rvalid), 32'd0);
        checkOutput("rst_bvalid", 32'(axiIf.bvalid), 32'd0);
        checkOutput("rst_rlast", 32'(axiIf.rlast), 32'd0);
        checkOutput("rst_rresp", 32'(axiIf.rresp), 32'd0);
        checkOutput("rst_bresp", 32'(axiIf.bresp), 32'd0);
        checkOutput("rst_ram_en", 32'(ramEn), 32'd0);
        checkOutput("rst_ram_we", 32'(ramWe), 32'd0);
        @(negedge clk); resetn = 1'b1;

        $display("[TB] contention after reset");
        for (int k = 0; k < 2; k++) begin
            setRead(4'd2, 32'h0000_0080 + 32'(k * 64), 8'd1, 2'b01, 3'd2, 0);
            setWrite(4'd3, 32'h0000_00C0 + 32'(k * 64), 8'd1, 2'b01, 3'd2, 1'b0);
            applyStimulus();
        end

        $display("[TB] single read and byte write");
        setRead(4'd1, 32'h0000_0400, 8'd0, 2'b01, 3'd2, 0);
        applyStimulus();
        checkOutput("t1_data", lastRdata, 32'hDEADBEEF);
        setWrite(4'd0, 32'h0000_0402, 8'd0, 2'b01, 3'd0, 1'b0);
        wrData[0] = 32'h00AB0000;
        wrStrb[0] = 4'b0100;
        applyStimulus();
        setRead(4'd1, 32'h0000_0400, 8'd0, 2'b01, 3'd2, 0);
        applyStimulus();
        checkOutput("t2_data", lastRdata, 32'hDEABBEEF);

        $display("[TB] stalled INCR read, FIXED write, early wlast");
        setRead(4'd4, 32'h0000_0010, 8'd3, 2'b01, 3'd2, 1);
        applyStimulus();
        setWrite(4'd6, 32'h0000_0020, 8'd1, 2'b00, 3'd2, 1'b0);
        wrStrb[0] = 4'hF;
        wrStrb[1] = 4'hF;
        applyStimulus();
        setRead(4'd6, 32'h0000_0020, 8'd0, 2'b00, 3'd2, 0);
        applyStimulus();
        checkOutput("t5_fixed", lastRdata, wrData[1]);
        setWrite(4'd7, 32'h0000_0200, 8'd3, 2'b01, 3'd2, 1'b1);
        applyStimulus();

        $display("[TB] 256-beat bursts");
        n = int'($urandom);
        setWrite(4'd8, 32'(n), 8'd255, 2'b01, 3'd2, 1'b0);
        applyStimulus();
        setRead(4'd9, 32'(n), 8'd255, 2'b01, 3'd2, 2);
        applyStimulus();

        $display("[TB] random traffic");
        for (int t = 0; t < 16; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind != 1) setRead(4'($urandom), $urandom, 8'($urandom_range(0, 15)), 2'($urandom),
                                   3'($urandom_range(0, 2)), $urandom_range(0, 2));
            if (kind != 0) setWrite(4'($urandom), $urandom, 8'($urandom_range(0, 15)), 2'($urandom),
                                    3'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
            applyStimulus();
        end

        $display("[TB] reset during read response");
        @(negedge clk);
        axiIf.arvalid = 1'b1; axiIf.arid = 4'd9; axiIf.araddr = 32'h0000_0040;
        axiIf.arlen = 8'd2; axiIf.arsize = 3'd2; axiIf.arburst = 2'b01; axiIf.rready = 1'b0;
        #1 checkOutput("t6_arready", 32'(axiIf.arready), 32'd1);
        @(posedge clk);
        #1 axiIf.arvalid = 1'b0;
        n = 0;
        while (!axiIf.rvalid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("t6_pre_rvalid", 32'(axiIf.rvalid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("t6_rvalid_drop", 32'(axiIf.rvalid), 32'd0);
        checkOutput("t6_rlast_drop", 32'(axiIf.rlast), 32'd0);
        checkOutput("t6_ram_en", 32'(ramEn), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        refLastWrite = 1'b1;
        setRead(4'd5, 32'h0000_0400, 8'd1, 2'b01, 3'd2, 0);
        setWrite(4'd2, 32'h0000_0800, 8'd0, 2'b01, 3'd2, 1'b0);
        applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
